// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory responder and the cache datapath.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

  localparam logic MRW_READ  = 1'b0;
  localparam logic MRW_WRITE = 1'b1;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;
  localparam int CNT_W      = 8;
endpackage

// File: rtl/main_memory_model_if.sv
// Request/response bus between the cache controller (master) and main memory (slave).
interface main_memory_model_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MDataIn;
  logic [DATA_W-1:0] MDataOut;
  logic              MReady;
  logic              MBusy;

  modport master (
    output MStrobe, MRW, MAddr, MDataIn,
    input  MDataOut, MReady, MBusy
  );

  modport slave (
    input  MStrobe, MRW, MAddr, MDataIn,
    output MDataOut, MReady, MBusy
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Loadable wait-state down-counter; done flags the last wait cycle (count == 1).
module mem_wait_timer
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));
endmodule

// File: rtl/main_memory_model.sv
// Single-word main-memory responder: accepts one request, completes it after
// WAIT_CYCLES wait states with a one-cycle MReady pulse.
module main_memory_model
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  main_memory_model_if.slave  bus
);
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("main_memory_model: WAIT_CYCLES=%0d outside 1..255", WAIT_CYCLES);
  end

  localparam logic [CNT_W-1:0] WAIT_VAL = CNT_W'(WAIT_CYCLES);

  mem_state_t        state;
  mem_state_t        state_nxt;
  logic              accept;
  logic              complete;
  logic              done;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MStrobe) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          complete  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mem_wait_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (WAIT_VAL),
    .done     (done)
  );

  // Request registers decouple the array access from later bus activity.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_rw   <= bus.MRW;
      req_addr <= bus.MAddr;
      req_data <= bus.MDataIn;
    end
  end

  // Reset on the completion edge suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!reset && complete && req_rw == MRW_WRITE) begin
      mem[req_addr] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.MDataOut <= '0;
    end else if (complete && req_rw == MRW_READ) begin
      bus.MDataOut <= mem[req_addr];
    end
  end

  assign bus.MReady = (state == RESP);
  assign bus.MBusy  = (state != IDLE);
endmodule

// File: tb/tb_main_memory_model.sv
// Randomized bench for main_memory_model with a transaction-level reference model.
module tb_main_memory_model;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  main_memory_model_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  main_memory_model_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

  main_memory_model #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  main_memory_model #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {24'hA5005A, a};
  endfunction

  // Reference model: one outstanding request, completing W edges after acceptance,
  // with the ready cycle followed by one edge during which new strobes are ignored.
  bit          m_active = 0;
  int          m_n = 0;
  int          m_acc = 0;
  bit          m_rw;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_mem [256];
  bit          m_known [256];
  logic        exp_ready = 1'b0;
  logic        exp_busy = 1'b0;
  logic [31:0] exp_dout = '0;
  bit          exp_dout_known = 1;
  bit          chk_en = 0;

  task automatic model_step();
    m_n++;
    exp_ready = 1'b0;
    if (reset) begin
      m_active = 0;
      exp_dout = '0;
      exp_dout_known = 1;
    end else if (!m_active) begin
      if (bus.MStrobe) begin
        m_active = 1;
        m_acc    = m_n;
        m_rw     = bus.MRW;
        m_addr   = bus.MAddr;
        m_data   = bus.MDataIn;
      end
    end else if (m_n == m_acc + W) begin
      if (m_rw) begin
        m_mem[m_addr]   = m_data;
        m_known[m_addr] = 1;
      end else begin
        exp_dout       = m_mem[m_addr];
        exp_dout_known = m_known[m_addr];
      end
      exp_ready = 1'b1;
    end else if (m_n == m_acc + W + 1) begin
      m_active = 0;
    end
    exp_busy = m_active;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  logic prev_ready = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ready", {31'd0, bus.MReady}, {31'd0, exp_ready});
      chk("busy", {31'd0, bus.MBusy}, {31'd0, exp_busy});
      if (exp_dout_known) chk("dout", bus.MDataOut, exp_dout);
      chk("ready_consecutive", {31'd0, prev_ready & bus.MReady}, 32'd0);
      prev_ready = bus.MReady;
    end
  end

  task automatic req(input bit rw, input logic [7:0] a, input logic [31:0] d,
                     output int edges, output logic [31:0] rdata);
    bit ok;
    ok = 0;
    edges = 0;
    @(posedge clk); #1;
    bus.MStrobe = 1'b1; bus.MRW = rw; bus.MAddr = a; bus.MDataIn = d;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.MReady === 1'b1) begin
        ok = 1;
        break;
      end
    end
    bus.MStrobe = 1'b0;
    rdata = bus.MDataOut;
    if (!ok) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic req1(input bit rw, input logic [7:0] a, input logic [31:0] d,
                      output int edges, output logic [31:0] rdata);
    bit ok;
    ok = 0;
    edges = 0;
    @(posedge clk); #1;
    bus1.MStrobe = 1'b1; bus1.MRW = rw; bus1.MAddr = a; bus1.MDataIn = d;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus1.MReady === 1'b1) begin
        ok = 1;
        break;
      end
    end
    bus1.MStrobe = 1'b0;
    rdata = bus1.MDataOut;
    if (!ok) chk("req1_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          pulses;
    logic [31:0] rd;
    bus.MStrobe = 0; bus.MRW = 0; bus.MAddr = '0; bus.MDataIn = '0;
    bus1.MStrobe = 0; bus1.MRW = 0; bus1.MAddr = '0; bus1.MDataIn = '0;

    @(posedge clk);
    chk_en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.MBusy}, 32'd0);
    chk("rst_ready", {31'd0, bus.MReady}, 32'd0);
    chk("rst_dout", bus.MDataOut, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    for (int a = 0; a < 256; a++) req(1'b1, 8'(a), pat(8'(a)), lat, rd);

    // Write 0xDEADBEEF @0x10, then read it back.
    req(1'b1, 8'h10, 32'hDEADBEEF, lat, rd);
    chk("wr_latency", lat, 5);
    chk("wr_dout_unchanged", rd, 32'h0);
    req(1'b0, 8'h10, 32'h0, lat, rd);
    chk("rd_latency", lat, 5);
    chk("rd_data", rd, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    chk("rd_data_held", bus.MDataOut, 32'hDEADBEEF);

    // Reset two cycles after accepting a write.
    @(posedge clk); #1;
    bus.MStrobe = 1; bus.MRW = 1; bus.MAddr = 8'h20; bus.MDataIn = 32'h12345678;
    @(posedge clk); #1 bus.MStrobe = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.MBusy}, 32'd0);
    req(1'b0, 8'h20, 32'h0, lat, rd);
    chk("abort_no_write", rd, 32'hA5005A20);

    // Bus changes and strobe pulses while busy are ignored.
    @(posedge clk); #1;
    bus.MStrobe = 1; bus.MRW = 1; bus.MAddr = 8'h11; bus.MDataIn = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.MStrobe = 0; bus.MAddr = 8'h30; bus.MDataIn = 32'h0;
    @(posedge clk); #1 bus.MStrobe = 1;
    @(posedge clk); #1 bus.MStrobe = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      pulses += int'(bus.MReady);
    end
    chk("busy_strobe_pulses", pulses, 1);
    req(1'b0, 8'h11, 32'h0, lat, rd);
    chk("busy_change_data", rd, 32'hCAFEF00D);
    req(1'b0, 8'h30, 32'h0, lat, rd);
    chk("busy_change_other", rd, 32'hA5005A30);

    // Strobe held continuously: one accept every W+2 cycles.
    @(posedge clk); #1;
    bus.MStrobe = 1; bus.MRW = 0; bus.MAddr = 8'h10;
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); @(negedge clk);
      pulses += int'(bus.MReady);
      bus.MAddr = (bus.MAddr == 8'h10) ? 8'h11 : 8'h10;
    end
    bus.MStrobe = 0;
    chk("held_pulses", pulses, 8);
    repeat (W + 3) @(posedge clk);

    // Random traffic with noise and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      bus.MStrobe = ($urandom % 3) != 0;
      bus.MRW     = 1'($urandom);
      bus.MAddr   = ($urandom % 8 != 0) ? 8'(8'h10 + $urandom_range(0, 7)) : 8'($urandom);
      bus.MDataIn = $urandom;
      reset       = ($urandom % 60) == 0;
    end
    @(negedge clk);
    bus.MStrobe = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Single wait-state instance.
    req1(1'b1, 8'h10, 32'h0BADCAFE, lat, rd);
    chk("w1_wr_latency", lat, 2);
    req1(1'b0, 8'h10, 32'h0, lat, rd);
    chk("w1_rd_latency", lat, 2);
    chk("w1_rd_data", rd, 32'h0BADCAFE);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
